cpu_run_ctrl: RTL
=================

Name: cpu_run_ctrl

Overview:
- Execution controller for the 24-bit CPU. Runs on the free-running `Clock` and produces the CPU clock-enable `CpuEn`.
- Supports three modes: free run, bounded run of N cycles, and single-step via a request/acknowledge handshake.
- Counts executed cycles and reports why execution stopped.
- Sits between the top-level/debug host and the CPU core, replacing fixed-length clock bursts with controlled execution.

Parameters:
- WIDTH, 24, width of CycleLimit, CycleCount and Pc/BreakAddr.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  level; sampled each cycle; begins a run.
- Stop  in  1  level; external stop request.
- StepReq  in  1  single-step request; acts on its rising edge only.
- StepAck  out  1  one-cycle pulse; the requested step has completed.
- CycleLimit  in  WIDTH  run bound sampled at Start; 0 means unbounded.
- HaltIn  in  1  CPU halt indication, e.g. HLT decoded.
- CpuEn  out  1  CPU clock-enable; registered.
- Running  out  1  high in RUN and STEP.
- Done  out  1  high in HALTED.
- DoneCause  out  2  00 none, 01 Stop, 10 HaltIn, 11 cycle limit.
- CycleCount  out  WIDTH  number of enabled cycles since the last Start.

Behaviour:
- Interface: one clock, `Clock`. Reset is synchronous and active-high on `Reset`. No asynchronous logic.
- Reset, or Reset asserted at any point mid-operation, forces on the next edge:
  - state IDLE;
  - CpuEn=0, StepAck=0, Running=0, Done=0;
  - DoneCause=00, CycleCount=0, LimitReg=0;
  - StepReq edge register = 0.
- States: IDLE, RUN, STEP, ACK, HALTED. CpuEn is registered and high exactly in the cycles where the state is RUN or STEP.
- Enabled cycles: every cycle with CpuEn=1 increments CycleCount. CycleCount saturates at 2^WIDTH-1 and never wraps.
- IDLE or HALTED, on Start=1:
  - go to RUN; CycleCount=0; LimitReg=CycleLimit; Done=0; DoneCause=00.
  - Start has priority over a StepReq edge in the same cycle.
- IDLE or HALTED, on a StepReq rising edge with Start=0:
  - go to STEP; CycleCount is retained; Done=0.
- RUN exit conditions, evaluated on each enabled cycle, in priority order:
  - Stop → HALTED with cause 01;
  - HaltIn → HALTED with cause 10;
  - LimitReg≠0 and CycleCount+1==LimitReg → HALTED with cause 11.
  - Consequence: with a limit of N the CPU receives exactly N enabled cycles.
- RUN latency: the condition is sampled on cycle k; CpuEn is low from cycle k+1.
- Start while in RUN is ignored.
- STEP: lasts exactly one enabled cycle, then goes to ACK.
  - If HaltIn is high in STEP, cause 10 is latched and the exit goes via ACK to HALTED.
- ACK: CpuEn=0 and StepAck=1 for one cycle, then go to IDLE, or to HALTED if a cause was latched.
- Step handshake: a new step requires StepReq to fall and rise again. A StepReq held high yields exactly one step.
- Stop in IDLE or HALTED has no effect. DoneCause is held until the next Start or Reset.

Optional Feature:
- Macro BREAKPOINT_EN.
- With it defined:
  - extra inputs Pc[WIDTH-1:0], BreakAddr[WIDTH-1:0] and BreakValid;
  - in RUN, Pc==BreakAddr with BreakValid=1 halts before the matching instruction executes: CpuEn is low from the next cycle and that cycle is not counted;
  - the cause reuses 01 and an extra output BreakHit=1 is raised until the next Start;
  - breakpoint priority sits between Stop and HaltIn.
- Without it: these ports are absent and behaviour is as above.

Decomposition:
- Shared package/header (cpu_pkg or defines include) holds:
  - state encodings (3-bit localparams);
  - DoneCause encodings CAUSE_NONE/STOP/HALT/LIMIT;
  - the WIDTH default of 24.
- One natural sub-module: sat_counter (WIDTH-bit, clear/enable, saturating) for CycleCount.

Test Plan:
- Reset mid-RUN (CycleCount=7) → next edge: CpuEn=0, CycleCount=0, Running=0, DoneCause=00.
- Start with CycleLimit=30, no Stop/HaltIn → exactly 30 cycles of CpuEn=1, then Done=1, DoneCause=11, CycleCount=30.
- Start with CycleLimit=0; HaltIn pulsed on the 12th enabled cycle → CycleCount=12, DoneCause=10, CpuEn low from the next cycle.
- Stop and HaltIn asserted in the same RUN cycle → DoneCause=01.
- StepReq held high for 5 cycles from IDLE → exactly one CpuEn pulse, one StepAck pulse one cycle later, CycleCount=1. A second rise gives CycleCount=2.
- Saturation: CycleCount forced to 2^24-2, then 3 enabled cycles → CycleCount=2^24-1, no wrap. With BREAKPOINT_EN: BreakAddr=0x000010 and Pc reaching 0x000010 → halt, BreakHit=1.

Source files
------------

// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_run_ctrl_pkg: shared state/cause encodings and default width for the CPU run controller
package cpu_run_ctrl_pkg;
  localparam int WIDTH_DEF = 24;
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_STEP   = 3'd2;
  localparam logic [2:0] ST_ACK    = 3'd3;
  localparam logic [2:0] ST_HALTED = 3'd4;
  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_RUN    = ST_RUN,
    S_STEP   = ST_STEP,
    S_ACK    = ST_ACK,
    S_HALTED = ST_HALTED
  } state_e;
  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_STOP  = 2'b01;
  localparam logic [1:0] CAUSE_HALT  = 2'b10;
  localparam logic [1:0] CAUSE_LIMIT = 2'b11;
endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// cpu_run_ctrl_sat_counter: WIDTH-bit up counter with clear and enable that sticks at all-ones
module cpu_run_ctrl_sat_counter
  import cpu_run_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);
  logic [WIDTH-1:0] count_q;
  // clear wins over enable; increments stop once every bit is set
  always_ff @(posedge clk) begin
    if (rst || clr_i) count_q <= '0;
    else if (en_i && count_q != '1) count_q <= count_q + WIDTH'(1);
  end
  assign count_o = count_q;
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: CPU clock-enable controller (free run, bounded run, single step); BREAKPOINT_EN adds a PC breakpoint
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stop,
  input  logic             StepReq,
  output logic             StepAck,
  input  logic [WIDTH-1:0] CycleLimit,
  input  logic             HaltIn,
`ifdef BREAKPOINT_EN
  input  logic [WIDTH-1:0] Pc,
  input  logic [WIDTH-1:0] BreakAddr,
  input  logic             BreakValid,
  output logic             BreakHit,
`endif
  output logic             CpuEn,
  output logic             Running,
  output logic             Done,
  output logic [1:0]       DoneCause,
  output logic [WIDTH-1:0] CycleCount
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [1:0]       cause_q, cause_d;
  logic             pend_q, pend_d;
  logic             step_q, cpu_en_q, ack_q;
  logic             step_rise, bp, clr, cnt_en, limit_hit;
`ifdef BREAKPOINT_EN
  logic             brk_q, brk_d;
  assign bp = BreakValid && Pc == BreakAddr;
  assign BreakHit = brk_q;
`else
  assign bp = 1'b0;
`endif
  assign step_rise = StepReq && !step_q;
  assign limit_hit = limit_q != '0 && ({1'b0, CycleCount} + (WIDTH+1)'(1)) == {1'b0, limit_q};
  // a breakpoint stops the CPU before the matching instruction, so that cycle is not counted
  assign cnt_en = cpu_en_q && !(state_q == S_RUN && !Stop && bp);
  // next-state, run bound, stop cause and pending-halt decisions
  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    cause_d = cause_q;
    pend_d  = pend_q;
    clr     = 1'b0;
`ifdef BREAKPOINT_EN
    brk_d   = brk_q;
`endif
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (Start) begin
          state_d = S_RUN;
          limit_d = CycleLimit;
          cause_d = CAUSE_NONE;
          clr     = 1'b1;
`ifdef BREAKPOINT_EN
          brk_d   = 1'b0;
`endif
        end else if (step_rise) begin
          state_d = S_STEP;
          pend_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (Stop) begin
          state_d = S_HALTED;
          cause_d = CAUSE_STOP;
        end else if (bp) begin
          state_d = S_HALTED;
          cause_d = CAUSE_STOP;
`ifdef BREAKPOINT_EN
          brk_d   = 1'b1;
`endif
        end else if (HaltIn) begin
          state_d = S_HALTED;
          cause_d = CAUSE_HALT;
        end else if (limit_hit) begin
          state_d = S_HALTED;
          cause_d = CAUSE_LIMIT;
        end
      end
      S_STEP: begin
        state_d = S_ACK;
        if (HaltIn) begin
          pend_d  = 1'b1;
          cause_d = CAUSE_HALT;
        end
      end
      S_ACK:   state_d = pend_q ? S_HALTED : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // state and registered outputs; CpuEn/StepAck are decoded from the next state so they align with it
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      limit_q  <= '0;
      cause_q  <= CAUSE_NONE;
      pend_q   <= 1'b0;
      step_q   <= 1'b0;
      cpu_en_q <= 1'b0;
      ack_q    <= 1'b0;
`ifdef BREAKPOINT_EN
      brk_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      limit_q  <= limit_d;
      cause_q  <= cause_d;
      pend_q   <= pend_d;
      step_q   <= StepReq;
      cpu_en_q <= state_d == S_RUN || state_d == S_STEP;
      ack_q    <= state_d == S_ACK;
`ifdef BREAKPOINT_EN
      brk_q    <= brk_d;
`endif
    end
  end
  cpu_run_ctrl_sat_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk    (Clock),
    .rst    (Reset),
    .clr_i  (clr),
    .en_i   (cnt_en),
    .count_o(CycleCount)
  );
  assign CpuEn     = cpu_en_q;
  assign StepAck   = ack_q;
  assign Running   = state_q == S_RUN || state_q == S_STEP;
  assign Done      = state_q == S_HALTED;
  assign DoneCause = cause_q;
endmodule
